run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
- Upstream control stage for the 9-bit processor top level.
- Accepts a run request from the host and streams preload bytes (message/seed data) into data memory through a dedicated write port.
- Drives the processor's Start for a fixed number of cycles, then waits for Ack.
- Reports completion, timeout and the measured run length in cycles.

Parameters:
AW, 8, data-memory address width (byte addressed)
DW, 8, data-memory / host byte width
START_CYCLES, 2, cycles Start is held high (>=1)
CNT_W, 16, width of run-cycle counter
TIMEOUT, 16'd4000, RUN cycles after which the run is aborted as timed out (must be < 2^CNT_W)

Ports:
Clk  in  1  clock, posedge
Reset  in  1  asynchronous, active-low reset
Go  in  1  run request; sampled only in IDLE or DONE
LoadBase  in  AW  first data-memory address for preload; latched with Go
LoadLen  in  AW+1  preload byte count, 0..256; 0 skips preload; latched with Go
HostValid  in  1  preload byte valid
HostData  in  DW  preload byte
HostReady  out  1  sequencer accepts a byte this cycle
DmWrEn  out  1  data-memory write enable
DmAddr  out  AW  data-memory write address
DmData  out  DW  data-memory write data
Start  out  1  to processor Start
Ack  in  1  processor done flag
Busy  out  1  high in LOAD, START, RUN
Done  out  1  level; run finished (Ack seen or timeout)
TimedOut  out  1  level; valid while Done
CycleCount  out  CNT_W  RUN-cycle count of the last run; valid while Done

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; internal counters and latches 0. Reset mid-load or mid-run aborts with no further writes.
- States: IDLE, LOAD, START, RUN, DONE. All outputs are registered.
- IDLE / DONE:
  - Go=1 latches LoadBase and LoadLen.
  - Goes to LOAD if LoadLen!=0, else START.
  - Go clears Done, TimedOut and CycleCount on the transition.
  - Go in any other state is ignored.
- LOAD:
  - HostReady=1.
  - Each cycle with HostValid&HostReady: next cycle DmWrEn=1, DmAddr=LoadBase+k (mod 2^AW, wraps 255->0), DmData=HostData, where k is the accepted-byte index.
  - DmWrEn is 0 otherwise.
  - On acceptance of byte LoadLen-1: HostReady drops the next cycle, then go to START. The final DmWrEn occurs in the first START cycle.
  - HostValid while not in LOAD is ignored.
- START:
  - Start=1 for exactly START_CYCLES cycles, then RUN.
  - Ack is ignored in START, because the processor may still present a stale Ack from the previous program.
- RUN:
  - Start=0; counter cleared on entry.
  - Counter increments each cycle Ack=0.
  - Ack=1: go to DONE; CycleCount=counter (not including the Ack cycle); TimedOut=0.
  - Counter reaching TIMEOUT with Ack=0: go to DONE; TimedOut=1; CycleCount=TIMEOUT.
  - Ack and timeout in the same cycle: Ack wins, TimedOut=0.
- DONE: Done=1, Busy=0; outputs held until the next Go.
- Latency: Go to first Start = 1 cycle if LoadLen=0, else LoadLen + 1 cycles minimum (host stalls extend this).
- LoadLen=256 writes all addresses once; the address wraps only after the last byte.

Decomposition:
- Shared package run_seq_pkg:
  - state enum (IDLE, LOAD, START, RUN, DONE)
  - default parameter constants (AW, DW, CNT_W, TIMEOUT, START_CYCLES)
- One natural sub-module: run_cycle_counter. It provides clear, enable, compare-to-TIMEOUT and a hit flag, and is reusable by the top-level cycle statistics.

Test Plan:
- Reset low mid-RUN (after 10 cycles) -> next cycle all outputs 0 and state IDLE. After release, a Go with LoadLen=0 gives Start high 2 cycles.
- Go, LoadBase=8'h40, LoadLen=3, bytes A1/B2/C3 with HostValid always high -> DmWrEn on 3 consecutive cycles at 40/41/42 with A1/B2/C3, then Start 2 cycles.
- LoadBase=8'hFE, LoadLen=4, HostValid toggling every other cycle -> writes to FE, FF, 00, 01 in order; no write on idle cycles; HostReady low after the 4th accept.
- LoadLen=0; Ack held high through START, dropped, then raised 25 RUN cycles later -> Done=1, TimedOut=0, CycleCount=25.
- Ack never asserted, TIMEOUT=4000 -> Done=1, TimedOut=1, CycleCount=4000. A second Go in DONE clears the flags and restarts.
- Ack rises on the exact cycle the counter hits TIMEOUT -> TimedOut=0; Go during RUN is ignored (no restart, no latch change).

Source files
------------

// File: rtl/run_seq_pkg.sv
// Shared types and default parameters for the run sequencer: FSM state
// encoding and the default widths/timing used by the top and its counter.
package run_seq_pkg;

    localparam int unsigned AW_DEF           = 8;
    localparam int unsigned DW_DEF           = 8;
    localparam int unsigned START_CYCLES_DEF = 2;
    localparam int unsigned CNT_W_DEF        = 16;
    localparam int unsigned TIMEOUT_DEF      = 4000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/run_sequencer_if.sv
// Host-side bundle of the run sequencer: run request, preload stream,
// data-memory write port, processor handshake and run status.
interface run_sequencer_if #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned CNT_W = 16
);
    logic             Go;
    logic [AW-1:0]    LoadBase;
    logic [AW:0]      LoadLen;
    logic             HostValid;
    logic [DW-1:0]    HostData;
    logic             HostReady;
    logic             DmWrEn;
    logic [AW-1:0]    DmAddr;
    logic [DW-1:0]    DmData;
    logic             Start;
    logic             Ack;
    logic             Busy;
    logic             Done;
    logic             TimedOut;
    logic [CNT_W-1:0] CycleCount;

    // Host / processor side: drives requests and Ack, observes status.
    modport master (
        output Go, LoadBase, LoadLen, HostValid, HostData, Ack,
        input  HostReady, DmWrEn, DmAddr, DmData, Start, Busy, Done,
               TimedOut, CycleCount
    );

    // Sequencer side.
    modport slave (
        input  Go, LoadBase, LoadLen, HostValid, HostData, Ack,
        output HostReady, DmWrEn, DmAddr, DmData, Start, Busy, Done,
               TimedOut, CycleCount
    );

endinterface

// File: rtl/run_cycle_counter.sv
// Clearable, enabled cycle counter with a registered-free compare against a
// fixed limit; hit is high while the count equals LIMIT.
module run_cycle_counter #(
    parameter int unsigned      CNT_W = 16,
    parameter logic [CNT_W-1:0] LIMIT = '1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == LIMIT);

endmodule

// File: rtl/run_sequencer.sv
// Run sequencer: preloads data memory from a host byte stream, pulses the
// processor Start, then times the run until Ack or timeout.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned AW           = AW_DEF,
    parameter int unsigned DW           = DW_DEF,
    parameter int unsigned START_CYCLES = START_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    run_sequencer_if.slave  bus
);

    localparam int unsigned SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    state_e           state, state_nxt;

    logic [AW-1:0]    base_q, base_n;
    logic [AW:0]      len_q, len_n;
    logic [AW:0]      acc_q, acc_n;
    logic [SC_W-1:0]  sc_q, sc_n;

    logic             ready_q, ready_n;
    logic             wr_q, wr_n;
    logic [AW-1:0]    addr_q, addr_n;
    logic [DW-1:0]    data_q, data_n;
    logic             start_q, start_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             to_q, to_n;
    logic [CNT_W-1:0] cc_q, cc_n;

    logic             cnt_clear, cnt_en, cnt_hit;
    logic [CNT_W-1:0] cnt;

    run_cycle_counter #(
        .CNT_W (CNT_W),
        .LIMIT (CNT_W'(TIMEOUT))
    ) u_counter (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cnt),
        .hit    (cnt_hit)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        base_n    = base_q;
        len_n     = len_q;
        acc_n     = acc_q;
        sc_n      = sc_q;
        ready_n   = 1'b0;
        wr_n      = 1'b0;
        addr_n    = addr_q;
        data_n    = data_q;
        start_n   = 1'b0;
        done_n    = done_q;
        to_n      = to_q;
        cc_n      = cc_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.Go) begin
                    base_n = bus.LoadBase;
                    len_n  = bus.LoadLen;
                    acc_n  = '0;
                    sc_n   = '0;
                    done_n = 1'b0;
                    to_n   = 1'b0;
                    cc_n   = '0;
                    if (bus.LoadLen != '0) begin
                        state_nxt = ST_LOAD;
                        ready_n   = 1'b1;
                    end else begin
                        state_nxt = ST_START;
                        start_n   = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                ready_n = 1'b1;
                if (bus.HostValid && ready_q) begin
                    wr_n   = 1'b1;
                    addr_n = base_q + acc_q[AW-1:0];
                    data_n = bus.HostData;
                    acc_n  = acc_q + 1'b1;
                    if (acc_q == len_q - 1'b1) begin
                        state_nxt = ST_START;
                        ready_n   = 1'b0;
                        start_n   = 1'b1;
                    end
                end
            end

            // Ack is deliberately not looked at here: it may be stale.
            ST_START: begin
                if (sc_q == SC_W'(START_CYCLES - 1)) begin
                    state_nxt = ST_RUN;
                    cnt_clear = 1'b1;
                end else begin
                    start_n = 1'b1;
                    sc_n    = sc_q + 1'b1;
                end
            end

            // Ack takes priority over a coincident timeout.
            ST_RUN: begin
                if (bus.Ack) begin
                    state_nxt = ST_DONE;
                    done_n    = 1'b1;
                    to_n      = 1'b0;
                    cc_n      = cnt;
                end else if (cnt_hit) begin
                    state_nxt = ST_DONE;
                    done_n    = 1'b1;
                    to_n      = 1'b1;
                    cc_n      = cnt;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase

        busy_n = (state_nxt == ST_LOAD) || (state_nxt == ST_START) ||
                 (state_nxt == ST_RUN);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            base_q  <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            sc_q    <= '0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            cc_q    <= '0;
        end else begin
            base_q  <= base_n;
            len_q   <= len_n;
            acc_q   <= acc_n;
            sc_q    <= sc_n;
            ready_q <= ready_n;
            wr_q    <= wr_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            start_q <= start_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            to_q    <= to_n;
            cc_q    <= cc_n;
        end
    end

    assign bus.HostReady  = ready_q;
    assign bus.DmWrEn     = wr_q;
    assign bus.DmAddr     = addr_q;
    assign bus.DmData     = data_q;
    assign bus.Start      = start_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.TimedOut   = to_q;
    assign bus.CycleCount = cc_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: preload writes are checked through a
// timed scoreboard; run status is checked at each step.
module tb_run_sequencer;

    localparam int TO = 4000;

    logic Clk = 1'b0;
    logic Reset;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] bytes_q[$];

    run_sequencer_if #(.AW(8), .DW(8), .CNT_W(16)) bus ();

    run_sequencer dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    // Every DmWrEn must match the oldest pending accept, one cycle later.
    always @(negedge Clk) begin
        if (Reset === 1'b1 && bus.DmWrEn === 1'b1) begin
            check("wr_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                wr_t e;
                e = sb.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", bus.DmAddr, e.addr);
                check("wr_data", bus.DmData, e.data);
            end
        end
    end

    task automatic go(input logic [7:0] base, input logic [8:0] len);
        bus.Go       = 1'b1;
        bus.LoadBase = base;
        bus.LoadLen  = len;
        tick();
        bus.Go = 1'b0;
    endtask

    task automatic load_bytes(input logic [7:0] base, input bit toggle);
        int i = 0;
        int g = 0;
        while (i < bytes_q.size() && g < 100) begin
            bus.HostValid = !(toggle && (g % 2 == 1));
            bus.HostData  = bytes_q[i];
            if (bus.HostValid && bus.HostReady === 1'b1) begin
                sb.push_back('{cyc: cyc + 1, addr: base + 8'(i), data: bytes_q[i]});
                i++;
            end
            tick();
            g++;
        end
        bus.HostValid = 1'b0;
        check("load_accepts", i, bytes_q.size());
    endtask

    task automatic start_phase(input string tag);
        int hi = 0;
        while (bus.Start === 1'b1 && hi < 10) begin
            hi++;
            tick();
        end
        check(tag, hi, 2);
    endtask

    task automatic run_ack(input int k);
        bus.Ack = 1'b0;
        for (int j = 0; j < k; j++) tick();
        bus.Ack = 1'b1;
        tick();
        bus.Ack = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic to, input int cc);
        check({tag, "_done"}, {bus.Done, bus.Busy}, 2'b10);
        check({tag, "_to"}, bus.TimedOut, to);
        check({tag, "_cc"}, bus.CycleCount, cc);
    endtask

    initial begin
        Reset         = 1'b0;
        bus.Go        = 1'b0;
        bus.LoadBase  = '0;
        bus.LoadLen   = '0;
        bus.HostValid = 1'b0;
        bus.HostData  = '0;
        bus.Ack       = 1'b0;
        tick();
        tick();
        check("rst_outs", {bus.HostReady, bus.DmWrEn, bus.DmAddr, bus.DmData,
                           bus.Start, bus.Busy, bus.Done, bus.TimedOut}, 0);
        check("rst_cc", bus.CycleCount, 0);
        Reset = 1'b1;
        tick();

        // Reset asserted 10 cycles into RUN aborts immediately.
        go(8'h00, 9'd0);
        check("t1_start_lat", {bus.Start, bus.Busy}, 2'b11);
        start_phase("t1_start_len");
        for (int j = 0; j < 10; j++) tick();
        check("t1_in_run", {bus.Busy, bus.Start, bus.Done}, 3'b100);
        Reset = 1'b0;
        #1;
        check("t1_async_rst", {bus.HostReady, bus.DmWrEn, bus.Start, bus.Busy,
                               bus.Done, bus.TimedOut}, 0);
        tick();
        check("t1_rst_held", {bus.Busy, bus.CycleCount}, 0);
        Reset = 1'b1;
        tick();
        go(8'h00, 9'd0);
        check("t1b_start_lat", bus.Start, 1);
        start_phase("t1b_start_len");
        run_ack(5);
        check_done("t1b", 1'b0, 5);

        // Back-to-back preload of three bytes at 0x40.
        go(8'h40, 9'd3);
        check("t2_ready", {bus.HostReady, bus.Start, bus.DmWrEn}, 3'b100);
        bytes_q = '{8'hA1, 8'hB2, 8'hC3};
        load_bytes(8'h40, 1'b0);
        check("t2_after_load", {bus.HostReady, bus.Start, bus.DmWrEn}, 3'b011);
        start_phase("t2_start_len");
        check("t2_sb_empty", sb.size(), 0);
        run_ack(3);
        check_done("t2", 1'b0, 3);

        // Throttled preload that wraps the address past 0xFF.
        go(8'hFE, 9'd4);
        bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_bytes(8'hFE, 1'b1);
        check("t3_after_load", {bus.HostReady, bus.Start}, 2'b01);
        start_phase("t3_start_len");
        check("t3_sb_empty", sb.size(), 0);
        run_ack(0);
        check_done("t3", 1'b0, 0);

        // Stale Ack held through START must not end the run.
        bus.Ack = 1'b1;
        go(8'h00, 9'd0);
        start_phase("t4_start_len");
        check("t4_busy", {bus.Busy, bus.Done}, 2'b10);
        run_ack(25);
        check_done("t4", 1'b0, 25);

        // Timeout with no Ack, then restart from DONE.
        go(8'h00, 9'd0);
        start_phase("t5_start_len");
        bus.Ack = 1'b0;
        for (int j = 0; j < TO; j++) tick();
        check("t5_pre_to", {bus.Busy, bus.Done}, 2'b10);
        tick();
        check_done("t5", 1'b1, TO);
        go(8'h00, 9'd0);
        check("t5_clear", {bus.Done, bus.TimedOut, bus.CycleCount}, 0);
        check("t5_restart", {bus.Start, bus.Busy}, 2'b11);
        start_phase("t6_start_len");

        // Ack on the exact hit cycle wins; Go mid-run is ignored.
        for (int k = 0; k < TO; k++) begin
            bus.Go       = (k == 100);
            bus.LoadBase = 8'h33;
            bus.LoadLen  = 9'd5;
            tick();
            if (k == 100) check("t6_go_ignored", {bus.HostReady, bus.Start, bus.Busy}, 3'b001);
        end
        bus.Go  = 1'b0;
        bus.Ack = 1'b1;
        tick();
        bus.Ack = 1'b0;
        check_done("t6", 1'b0, TO);
        tick();
        tick();
        check("t6_hold", {bus.Done, bus.Start, bus.HostReady, bus.CycleCount}, {3'b100, 16'(TO)});
        check("end_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
